// File: rtl/shift_req_scheduler.sv
// shift_req_scheduler: round-robin sharing of one 8-bit barrel shifter among NREQ requesters
// Amounts 8..15 run as a 7-bit pass followed by a 1-bit pass.
module shift_req_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [4*NREQ-1:0] req_amt,
   input  logic [NREQ-1:0]   req_dir,
   input  logic [NREQ-1:0]   req_arith,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [7:0]        rsp_data,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        bs_in,
   output logic [3:0]        bs_ctrl,
   output logic              bs_dir,
   output logic              bs_arith,
   input  logic [7:0]        bs_out
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] EXEC1 = 2'd1;
   localparam logic [1:0] EXEC2 = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;
   logic [1:0]     state;
   logic [IDW-1:0] rr_ptr, gnt_idx, op_id;
   logic [IDW:0]   sel;
   logic           gnt_found, exec;
   logic [7:0]     op_data;
   logic [3:0]     op_amt;
   logic           op_dir, op_arith;
   // first valid requester at or after rr_ptr, wrapping past NREQ-1
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx = '0;
      sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         sel = {1'b0, rr_ptr} + (IDW+1)'(k);
         sel = sel >= (IDW+1)'(NREQ) ? sel - (IDW+1)'(NREQ) : sel;
         if (!gnt_found && req_valid[sel[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx = sel[IDW-1:0];
         end
      end
   end
   assign exec      = state == EXEC1 || state == EXEC2;
   assign req_ready = (state == IDLE && gnt_found && !rst) ? NREQ'(1) << gnt_idx : '0;
   assign bs_in     = exec ? op_data : 8'd0;
   assign bs_ctrl   = state == EXEC1 ? (op_amt[3] ? 4'd7 : op_amt) : state == EXEC2 ? 4'd1 : 4'd0;
   assign bs_dir    = exec & op_dir;
   assign bs_arith  = exec & op_dir & op_arith;
   assign rsp_valid = state == RESP;
   assign rsp_data  = op_data;
   assign rsp_id    = op_id;
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         op_data  <= '0;
         op_amt   <= '0;
         op_dir   <= 1'b0;
         op_arith <= 1'b0;
         op_id    <= '0;
      end else begin
         case (state)
            IDLE: if (gnt_found) begin
               op_data  <= req_data[8*gnt_idx +: 8];
               op_amt   <= req_amt[4*gnt_idx +: 4];
               op_dir   <= req_dir[gnt_idx];
               op_arith <= req_arith[gnt_idx];
               op_id    <= gnt_idx;
               rr_ptr   <= gnt_idx == IDW'(NREQ-1) ? '0 : gnt_idx + 1'b1;
               state    <= EXEC1;
            end
            EXEC1: begin
               op_data <= bs_out;
               state   <= op_amt[3] ? EXEC2 : RESP;
            end
            EXEC2: begin
               op_data <= bs_out;
               state   <= RESP;
            end
            default: if (rsp_ready) state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/shift_req_scheduler.md
Name: shift_req_scheduler

Overview:
Time-multiplexes one shared barrel_shift_8bit instance among NREQ requesters. A round-robin arbiter picks the next request, and a small FSM sequences the shifter. Shift amounts 8..15 run as two shifter passes, because the shifter itself accepts only 0..7. Results return on a single valid/ready response channel tagged with the requester index.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id; must equal clog2(NREQ)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high
req_data  in  8*NREQ  operand; requester i uses bits [8i+7:8i]
req_amt  in  4*NREQ  shift amount 0..15; requester i uses bits [4i+3:4i]
req_dir  in  NREQ  1 = right shift, 0 = left shift
req_arith  in  NREQ  1 = sign fill on right shift; ignored on left shift
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_data  out  8  shifted result
rsp_id  out  IDW  index of the requester that owns the result
bs_in  out  8  to shifter in
bs_ctrl  out  4  to shifter ctrl; always 0..7
bs_dir  out  1  to shifter dir
bs_arith  out  1  to shifter arithmetic
bs_out  in  8  from shifter out (combinational)

Behaviour:
- Clocking and reset: single clock domain, clk. rst is synchronous, active-high.
- State on reset: FSM to IDLE; rr_ptr=0; op registers cleared.
- Outputs in reset: rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, bs_in=0, bs_ctrl=0, bs_dir=0, bs_arith=0.
- FSM states: IDLE, EXEC1, EXEC2, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from rr_ptr upward with wrap.
  - req_ready is combinational: one-hot on the granted index, only while in IDLE.
  - On accept (req_valid & req_ready at cycle T), register op_data, op_amt, op_dir, op_arith, op_id.
  - Set rr_ptr = (granted index + 1) mod NREQ, then go to EXEC1.
  - With no valid request: stay in IDLE, rr_ptr unchanged.
- EXEC1 (T+1):
  - Drive bs_in=op_data, bs_dir=op_dir, bs_arith=op_arith & op_dir.
  - bs_ctrl = op_amt if op_amt<8, else 7.
  - Capture bs_out into op_data.
  - Next state: RESP if op_amt<8, else EXEC2.
- EXEC2 (T+2, only when op_amt>=8):
  - Drive bs_in=op_data (pass-1 result) with bs_ctrl=1 and the same dir/arith.
  - Capture bs_out, then go to RESP.
  - 7+1=8 fully fills the word, so any amount 8..15 yields: right arithmetic -> {8{op sign}}; right logical or left -> 8'h00.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id come from registers and stay stable until rsp_ready=1.
  - On rsp_valid & rsp_ready, return to IDLE next cycle. No new request is accepted in that same cycle.
- Latency, accept to rsp_valid: 2 cycles when amt<8, 3 cycles when amt>=8. Minimum spacing between accepts: 3 cycles.
- Shifter drive outside EXEC1/EXEC2: bs_* held at 0.
- bs_ctrl never exceeds 7, so the shifter's invalid-amount path is never triggered.
- Request changes: a requester may change or drop req_valid at any time before acceptance, with no side effects. Non-granted requesters are never stalled indefinitely; worst-case wait is NREQ-1 grants.
- Reset mid-operation: the in-flight op is discarded with no response, and all state and outputs return to reset values the next cycle.

Test Plan:
1. Requester 1: data 8'b11010001, amt 2, dir 1, arith 1 -> rsp_data 8'b11110100, rsp_id 1, rsp_valid exactly 2 cycles after accept.
2. Requester 0: data 8'b11010001, amt 3, dir 0 -> rsp_data 8'b10001000. Same data, amt 10, dir 1, arith 1 -> 8'hFF, 3-cycle latency, bs_ctrl sequence 7 then 1. Amt 9, dir 1, arith 0 -> 8'h00. Amt 15, dir 0 -> 8'h00.
3. All 4 requesters hold req_valid continuously, rr_ptr=0 after reset -> grant order 0,1,2,3,0. req_ready is never multi-hot and is 0 outside IDLE.
4. rsp_ready held low 5 cycles while rsp_valid=1 -> rsp_data and rsp_id stable throughout, no accepts occur. Raising rsp_ready -> IDLE on the next cycle.
5. Assert rst during EXEC2 of an amt=12 op -> next cycle all outputs at reset values, no response is ever emitted. The next request is granted starting from index 0.
6. Single requester 2 toggles req_valid every other cycle -> each accepted op returns the correct result with rsp_id=2, and no spurious grants occur while req_valid=0.
